// File: rtl/arith_scheduler.sv
// Round-robin sharing of one 16-bit arithmetic unit between two requesters,
// with registered operands and a tagged, registered response handshake.

module arithmetic (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [2:0]  i_op,
    output logic [31:0] o_result,
    output logic        o_flag
);
    logic [32:0] w_diff;

    assign w_diff = {17'd0, i_a} - {17'd0, i_b};

    // Operands are zero-extended; only subtraction produces a flag (borrow)
    always_comb begin
        o_result = '0;
        o_flag   = 1'b0;
        case (i_op)
            3'b000: o_result = 32'(i_a) + 32'(i_b);
            3'b001: begin
                o_result = w_diff[31:0];
                o_flag   = w_diff[32];
            end
            3'b010: o_result = 32'(i_a) + 32'd1;
            3'b011: o_result = 32'(i_b) + 32'd1;
            3'b100: o_result = 32'(i_a) - 32'd1;
            3'b101: o_result = 32'(i_b) - 32'd1;
            3'b110: o_result = 32'(i_a);
            3'b111: o_result = (i_a > i_b) ? 32'(i_a) : 32'(i_b);
        endcase
    end
endmodule

module arith_scheduler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [15:0]       req0_a,
    input  logic [15:0]       req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [15:0]       req1_a,
    input  logic [15:0]       req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [31:0]       rsp_result,
    output logic              rsp_flag,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic              r_id;
    logic              r_last_grant;
    logic [RES_W-1:0]  w_result;
    logic              w_flag;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [RES_W-1:0]  r_rsp_result;
    logic              r_rsp_flag;
    logic              r_busy;
    logic [CNT_W-1:0]  r_done_cnt;

    arithmetic u_arith (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_flag   (w_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Grant and next state; on contention the port not granted last wins
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_gnt0 = r_last_grant;
                    w_gnt1 = !r_last_grant;
                end else begin
                    w_gnt0 = req0_valid;
                    w_gnt1 = req1_valid;
                end
                if (req0_valid || req1_valid) w_state_next = S_EXEC;
            end
            S_EXEC: w_state_next = S_RESP;
            S_RESP: if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flag   <= 1'b0;
            r_busy       <= 1'b0;
            r_done_cnt   <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_a          <= w_gnt1 ? req1_a  : req0_a;
                r_b          <= w_gnt1 ? req1_b  : req0_b;
                r_op         <= w_gnt1 ? req1_op : req0_op;
                r_id         <= w_gnt1;
                r_last_grant <= w_gnt1;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= w_result;
                r_rsp_flag   <= w_flag;
                r_rsp_id     <= r_id;
                r_rsp_valid  <= 1'b1;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_done_cnt  <= r_done_cnt + CNT_W'(1);
            end
            r_busy <= (w_state_next != S_IDLE);
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flag   = r_rsp_flag;
    assign busy       = r_busy;
    assign done_cnt   = r_done_cnt;
endmodule

// File: tb/tb_arith_scheduler.sv
// Randomized, self-checking bench for arith_scheduler against a behavioural
// model of the arithmetic ops, arbitration order and response timing.

module tb_arith_scheduler;
    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
    logic [31:0] rsp_result;
    logic [15:0] done_cnt;

    logic        req0_ready2, req1_ready2, rsp_valid2, rsp_id2, rsp_flag2, busy2;
    logic [31:0] rsp_result2;
    logic [1:0]  done_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    arith_scheduler #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag),
        .busy(busy), .done_cnt(done_cnt)
    );

    arith_scheduler #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready2),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready2),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_result(rsp_result2), .rsp_flag(rsp_flag2),
        .busy(busy2), .done_cnt(done_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grants must be mutually exclusive in every cycle
    always @(posedge clk) begin
        if (rst_n) begin
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL ready_exclusive: req0_ready=%0b req1_ready=%0b required not both 1", req0_ready, req1_ready);
            end
        end
    end

    // Reference behaviour: returns {flag, result}
    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        longint ua;
        longint ub;
        longint r;
        logic   f;
        ua = longint'(a);
        ub = longint'(b);
        f  = 1'b0;
        r  = 0;
        case (op)
            3'd0: r = ua + ub;
            3'd1: begin r = ua - ub; f = (a < b); end
            3'd2: r = ua + 1;
            3'd3: r = ub + 1;
            3'd4: r = ua - 1;
            3'd5: r = ub - 1;
            3'd6: r = ua;
            default: r = (ua > ub) ? ua : ub;
        endcase
        return {f, r[31:0]};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    // Issue one request and collect its response with rsp_ready held high
    task automatic do_op(input bit port, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output logic [31:0] res, output logic flg, output logic id, output int lat);
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (port) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else      begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        n = 0;
        #1;
        while (!(port ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL accept_timeout: port %0d not granted within 50 cycles", port);
            req0_valid = 1'b0; req1_valid = 1'b0;
            res = '0; flg = 1'b0; id = 1'b0; lat = -1;
            return;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk); lat++;
        end
        res = rsp_result; flg = rsp_flag; id = rsp_id;
        @(negedge clk);
        if (lat < 50) exp_cnt++;
    endtask

    task automatic check_op(input string name, input bit port, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [31:0] res;
        logic        flg, id;
        int          lat;
        logic [32:0] exp;
        do_op(port, a, b, op, res, flg, id, lat);
        exp = model(a, b, op);
        checks++;
        if (res !== exp[31:0] || flg !== exp[32] || id !== port || lat != 2) begin
            errors++;
            $display("FAIL %s: got result=%h flag=%0b id=%0b lat=%0d, required result=%h flag=%0b id=%0b lat=2 (op=%0d a=%h b=%h)",
                     name, res, flg, id, lat, exp[31:0], exp[32], port, op, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_flag !== 1'b0 ||
            busy !== 1'b0 || done_cnt !== 16'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%0b id=%0b result=%h flag=%0b busy=%0b cnt=%0d, required all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_flag, busy, done_cnt);
        end
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        check_op("add_carry", 1'b0, 16'hFFFF, 16'h0001, 3'd0);
        checks++;
        if (done_cnt !== 16'(exp_cnt) || exp_cnt != 1) begin
            errors++;
            $display("FAIL done_cnt_first: got %0d required 1", done_cnt);
        end
        check_op("sub_borrow", 1'b1, 16'd3, 16'd5, 3'd1);
        check_op("dec_a_zero", 1'b1, 16'd0, 16'd9, 3'd4);
        check_op("pass_a", 1'b0, 16'd7, 16'd9, 3'd6);
        check_op("max_b", 1'b0, 16'd7, 16'd9, 3'd7);
        check_op("max_a", 1'b1, 16'd9, 16'd7, 3'd7);
        check_op("dec_b_zero", 1'b0, 16'd4, 16'd0, 3'd5);
        check_op("inc_b_full", 1'b1, 16'd0, 16'hFFFF, 3'd3);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 6 == 0) a = 16'hFFFF;
            if (i % 6 == 1) b = a;
            check_op("random_op", 1'($urandom_range(0, 1)), a, b, 3'($urandom_range(0, 7)));
        end
        checks++;
        if (done_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL done_cnt_random: got %0d required %0d", done_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int          grants[$];
        int          ids[$];
        int          n;
        logic [32:0] exp0, exp1, exp;
        apply_reset();
        @(negedge clk);
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
        exp0 = model(req0_a, req0_b, req0_op);
        exp1 = model(req1_a, req1_b, req1_op);
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (ids.size() < 4 && n < 60) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                exp = rsp_id ? exp1 : exp0;
                checks++;
                if (rsp_result !== exp[31:0] || rsp_flag !== exp[32]) begin
                    errors++;
                    $display("FAIL b2b_result: got %h/%0b required %h/%0b", rsp_result, rsp_flag, exp[31:0], exp[32]);
                end
            end
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_cnt += ids.size();
        checks++;
        if (grants.size() != 4 || ids.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants %0d responses, required 4 and 4", grants.size(), ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != i % 2 || ids[i] != i % 2) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: grant=%0d id=%0d required %0d", i, grants[i], ids[i], i % 2);
                end
            end
        end
        checks++;
        if (done_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL b2b_done_cnt: got %0d required %0d", done_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp1, exp0;
        logic [31:0] held_res;
        logic        held_flag;
        int          n;
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
        exp1 = model(req1_a, req1_b, req1_op);
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant1: req1_ready=%0b required 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
        exp0 = model(req0_a, req0_b, req0_op);
        req0_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        held_res  = rsp_result;
        held_flag = rsp_flag;
        checks++;
        if (rsp_valid !== 1'b1 || held_res !== exp1[31:0] || held_flag !== exp1[32] || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL bp_response: valid=%0b result=%h flag=%0b id=%0b required 1 %h %0b 1",
                     rsp_valid, held_res, held_flag, rsp_id, exp1[31:0], exp1[32]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp1[31:0] || rsp_flag !== exp1[32] ||
                rsp_id !== 1'b1 || req0_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%0b result=%h id=%0b req0_ready=%0b busy=%0b", i,
                         rsp_valid, rsp_result, rsp_id, req0_ready, busy);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_grant_in_resp: req0_ready=%0b required 0", req0_ready);
        end
        @(negedge clk); #1;
        exp_cnt++;
        checks++;
        if (req0_ready !== 1'b1 || rsp_valid !== 1'b0 || done_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL bp_regrant: req0_ready=%0b rsp_valid=%0b cnt=%0d required 1 0 %0d",
                     req0_ready, rsp_valid, done_cnt, exp_cnt);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== exp0[31:0] || rsp_flag !== exp0[32]) begin
            errors++;
            $display("FAIL bp_port0_rsp: valid=%0b id=%0b result=%h required 1 0 %h", rsp_valid, rsp_id, rsp_result, exp0[31:0]);
        end
        @(negedge clk);
        exp_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp;
        int          n;
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_a = 16'd11; req0_b = 16'd4; req0_op = 3'd1;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_exec_state: busy=%0b rsp_valid=%0b required 1 0", busy, rsp_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0 ||
            rsp_flag !== 1'b0 || done_cnt !== 16'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_values: busy=%0b valid=%0b result=%h cnt=%0d required all 0",
                     busy, rsp_valid, rsp_result, done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd0) begin
                errors++;
                $display("FAIL mid_no_response[%0d]: valid=%0b busy=%0b cnt=%0d required 0 0 0", i, rsp_valid, busy, done_cnt);
            end
        end
        req0_a = 16'h1234; req0_b = 16'h0F0F; req0_op = 3'd0;
        req1_a = 16'h0001; req1_b = 16'h0002; req1_op = 3'd0;
        exp = model(req0_a, req0_b, req0_op);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_contest: req0_ready=%0b req1_ready=%0b required 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp_id !== 1'b0 || rsp_result !== exp[31:0]) begin
            errors++;
            $display("FAIL mid_contest_rsp: id=%0b result=%h required 0 %h", rsp_id, rsp_result, exp[31:0]);
        end
        @(negedge clk);
        exp_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] res;
        logic        flg, id;
        int          lat;
        logic [32:0] exp;
        apply_reset();
        for (int i = 0; i < 5; i++) do_op(1'(i % 2), 16'(i * 3), 16'd2, 3'(i), res, flg, id, lat);
        exp = model(16'd12, 16'd2, 3'd4);
        checks++;
        if (done_cnt !== 16'd5 || done_cnt2 !== 2'd1) begin
            errors++;
            $display("FAIL cnt_wrap: wide=%0d narrow=%0d required 5 1", done_cnt, done_cnt2);
        end
        checks++;
        if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0 || req0_ready2 !== 1'b0 || req1_ready2 !== 1'b0 ||
            rsp_id2 !== 1'b0 || rsp_result2 !== exp[31:0] || rsp_flag2 !== exp[32]) begin
            errors++;
            $display("FAIL narrow_idle: valid=%0b busy=%0b id=%0b result=%h required 0 0 0 %h",
                     rsp_valid2, busy2, rsp_id2, rsp_result2, exp[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
